// File: rtl/seq_restoring_divider_if.sv
// Operand/result handshake bundle for seq_restoring_divider.
// The divider connects through the slave modport; its client connects through master.
interface seq_restoring_divider_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             busy;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, busy
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, busy
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider: one trial subtraction per clock, WIDTH iterations per result.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands and results (truncation toward zero).
module seq_restoring_divider #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_restoring_divider_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] rem_sh;
    logic [WIDTH-1:0] quo_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] iter_rem;
    logic [WIDTH-1:0] iter_quo;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] fin_quo;
    logic [WIDTH-1:0] fin_rem;
    logic             last_iter;

`ifdef SEQ_DIV_SIGNED_EN
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;
`endif

    // Datapath: one shift-and-trial-subtract step on the working {rem, quo} pair.
    always_comb begin
        rem_sh    = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        quo_sh    = {quo_q[WIDTH-2:0], 1'b0};
        trial     = {1'b0, rem_sh} - {1'b0, dvs_q};
        iter_rem  = trial[WIDTH] ? rem_sh : trial[WIDTH-1:0];
        iter_quo  = {quo_sh[WIDTH-1:1], ~trial[WIDTH]};
        last_iter = (cnt_q == CW'(WIDTH - 1));
`ifdef SEQ_DIV_SIGNED_EN
        // Magnitudes are divided; the most-negative value maps onto itself as an
        // unsigned magnitude, which makes most-negative / -1 come out as most-negative, 0.
        op_a    = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
        op_b    = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
        fin_quo = qneg_q ? -iter_quo : iter_quo;
        fin_rem = rneg_q ? -iter_rem : iter_rem;
`else
        op_a    = bus.dividend;
        op_b    = bus.divisor;
        fin_quo = iter_quo;
        fin_rem = iter_rem;
`endif
    end

    // Next-state and register updates.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
`ifdef SEQ_DIV_SIGNED_EN
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    if (bus.divisor == '0) begin
                        state_d     = S_DONE;
                        quotient_d  = '1;
                        remainder_d = bus.dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = S_CALC;
                        rem_d   = '0;
                        quo_d   = op_a;
                        dvs_d   = op_b;
                        cnt_d   = '0;
`ifdef SEQ_DIV_SIGNED_EN
                        qneg_d  = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        rneg_d  = bus.dividend[WIDTH-1];
`endif
                    end
                end
            end
            S_CALC: begin
                rem_d = iter_rem;
                quo_d = iter_quo;
                cnt_d = cnt_q + CW'(1);
                if (last_iter) begin
                    state_d     = S_DONE;
                    quotient_d  = fin_quo;
                    remainder_d = fin_rem;
                    dbz_d       = 1'b0;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
`ifdef SEQ_DIV_SIGNED_EN
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
`endif
        end
    end

    // Result registers are only written on entry to DONE, so they hold through back-pressure and after.
    assign bus.in_ready    = (state_q == S_IDLE);
    assign bus.out_valid   = (state_q == S_DONE);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider with a result scoreboard and latency checks.
module tb_seq_restoring_divider;
    localparam int unsigned W = 16;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    res_t sb[$];
    res_t last_exp;

    seq_restoring_divider_if #(.WIDTH(W)) bus ();

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        res_t             r;
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb_;
        sa  = a;
        sb_ = b;
        if (b == '0) begin
            r.q = '1; r.r = a; r.dbz = 1'b1;
        end else begin
            r.dbz = 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
                r.q = a; r.r = '0;
            end else begin
                r.q = sa / sb_;
                r.r = sa % sb_;
            end
`else
            r.q = a / b;
            r.r = a % b;
`endif
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        int n;
        if (push) sb.push_back(model(a, b));
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            tick();
            n++;
        end
        chk("accept_timeout", 32'(n < 200), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.dividend = W'($urandom);
        bus.divisor  = W'($urandom);
    endtask

    task automatic wait_out(input int exp_lat);
        int lat;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
    endtask

    task automatic take();
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        last_exp = sb.pop_front();
        chk("out_valid", 32'(bus.out_valid), 32'd1);
        chk("quotient", 32'(bus.quotient), 32'(last_exp.q));
        chk("remainder", 32'(bus.remainder), 32'(last_exp.r));
        chk("div_by_zero", 32'(bus.div_by_zero), 32'(last_exp.dbz));
        tick();
        chk("out_valid_drop", 32'(bus.out_valid), 32'd0);
        chk("in_ready_after", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b);
        send(a, b, 1'b1);
        wait_out((b == '0) ? 1 : int'(W) + 1);
        take();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_quotient", 32'(bus.quotient), 32'd0);
        chk("rst_remainder", 32'(bus.remainder), 32'd0);
        chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        rst = 1'b0;

        // 100/7 with busy visible mid-calculation
        send(16'd100, 16'd7, 1'b1);
        chk("busy_calc", 32'(bus.busy), 32'd1);
        chk("in_ready_calc", 32'(bus.in_ready), 32'd0);
        wait_out(W + 1);
        chk("busy_done", 32'(bus.busy), 32'd1);
        take();

        op(16'hFFFF, 16'h0001);
        op(16'h1234, 16'hFFFF);
        op(16'h00AB, 16'h0000);
        op(16'd5, 16'd9000);
        op(16'd0, 16'd77);
        op(16'hFFFF, 16'hFFFF);
        op(16'hFFFE, 16'h8001);

        // Back-pressure: result held for 5 cycles with out_ready low
        bus.out_ready = 1'b0;
        send(16'd1000, 16'd10, 1'b1);
        wait_out(W + 1);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
            chk("hold_quotient", 32'(bus.quotient), 32'(sb[0].q));
            chk("hold_remainder", 32'(bus.remainder), 32'(sb[0].r));
            tick();
        end
        bus.out_ready = 1'b1;
        take();
        tick();
        chk("keep_quotient", 32'(bus.quotient), 32'(last_exp.q));
        chk("keep_remainder", 32'(bus.remainder), 32'(last_exp.r));

        // Abort in CALC cycle 8
        send(16'd50000, 16'd3, 1'b0);
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_quotient", 32'(bus.quotient), 32'd0);
        chk("abort_remainder", 32'(bus.remainder), 32'd0);
        for (int i = 0; i < int'(W) + 3; i++) begin
            chk("abort_no_result", 32'(bus.out_valid), 32'd0);
            tick();
        end
        op(16'd9, 16'd3);

        // Reset wins over a simultaneous handshake
        bus.dividend = 16'd40;
        bus.divisor  = 16'd4;
        bus.in_valid = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        chk("rst_prio_busy", 32'(bus.busy), 32'd0);
        chk("rst_prio_in_ready", 32'(bus.in_ready), 32'd1);

`ifdef SEQ_DIV_SIGNED_EN
        op(16'hFFF9, 16'h0002);
        op(16'h8000, 16'hFFFF);
        op(16'h0007, 16'hFFFE);
        op(16'h8000, 16'h0000);
        op(16'hFFF9, 16'hFFFE);
`endif

        for (int i = 0; i < 10; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = W'($urandom);
            b = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom >> $urandom_range(0, 15));
            op(a, b);
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
